// File: rtl/inst_b_decoder.sv
// RV32 B-type instruction decoder with a single register stage on every output.
// Fields, immediate and target are produced for any opcode; is_branch qualifies them.
module inst_b_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instruction_word,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [6:0]      imm_MSB,
  output logic [4:0]      rs2,
  output logic [4:0]      rs1,
  output logic [2:0]      funct3,
  output logic [4:0]      imm_LSB,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] branch_target,
  output logic [5:0]      br_type,
  output logic            is_branch,
  output logic            illegal
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic            out_valid_d, out_valid_q;
  logic [6:0]      imm_msb_d, imm_msb_q;
  logic [4:0]      rs2_d, rs2_q;
  logic [4:0]      rs1_d, rs1_q;
  logic [2:0]      funct3_d, funct3_q;
  logic [4:0]      imm_lsb_d, imm_lsb_q;
  logic [XLEN-1:0] imm_b_d, imm_b_q;
  logic [XLEN-1:0] target_d, target_q;
  logic [5:0]      br_type_d, br_type_q;
  logic            is_branch_d, is_branch_q;
  logic            illegal_d, illegal_q;

  logic            opc_is_branch;
  logic [XLEN-1:0] imm_b_ext;
  logic [5:0]      br_onehot;

  assign opc_is_branch = (instruction_word[6:0] == OPC_BRANCH);
  assign imm_b_ext = {{(XLEN-12){instruction_word[31]}}, instruction_word[7],
                      instruction_word[30:25], instruction_word[11:8], 1'b0};

  always_comb begin
    br_onehot = 6'b000000;
    case (instruction_word[14:12])
      3'b000:  br_onehot = 6'b000001;
      3'b001:  br_onehot = 6'b000010;
      3'b100:  br_onehot = 6'b000100;
      3'b101:  br_onehot = 6'b001000;
      3'b110:  br_onehot = 6'b010000;
      3'b111:  br_onehot = 6'b100000;
      default: br_onehot = 6'b000000;
    endcase
  end

  // Decoded fields only update on a valid beat; otherwise the last decode is held.
  always_comb begin
    out_valid_d = in_valid;
    imm_msb_d   = imm_msb_q;
    rs2_d       = rs2_q;
    rs1_d       = rs1_q;
    funct3_d    = funct3_q;
    imm_lsb_d   = imm_lsb_q;
    imm_b_d     = imm_b_q;
    target_d    = target_q;
    br_type_d   = br_type_q;
    is_branch_d = is_branch_q;
    illegal_d   = illegal_q;
    if (in_valid) begin
      imm_msb_d   = instruction_word[31:25];
      rs2_d       = instruction_word[24:20];
      rs1_d       = instruction_word[19:15];
      funct3_d    = instruction_word[14:12];
      imm_lsb_d   = instruction_word[11:7];
      imm_b_d     = imm_b_ext;
      target_d    = pc + imm_b_ext;
      br_type_d   = opc_is_branch ? br_onehot : 6'b000000;
      is_branch_d = opc_is_branch && (br_onehot != 6'b000000);
      illegal_d   = opc_is_branch && (br_onehot == 6'b000000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      imm_msb_q   <= '0;
      rs2_q       <= '0;
      rs1_q       <= '0;
      funct3_q    <= '0;
      imm_lsb_q   <= '0;
      imm_b_q     <= '0;
      target_q    <= '0;
      br_type_q   <= '0;
      is_branch_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      imm_msb_q   <= imm_msb_d;
      rs2_q       <= rs2_d;
      rs1_q       <= rs1_d;
      funct3_q    <= funct3_d;
      imm_lsb_q   <= imm_lsb_d;
      imm_b_q     <= imm_b_d;
      target_q    <= target_d;
      br_type_q   <= br_type_d;
      is_branch_q <= is_branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign imm_MSB       = imm_msb_q;
  assign rs2           = rs2_q;
  assign rs1           = rs1_q;
  assign funct3        = funct3_q;
  assign imm_LSB       = imm_lsb_q;
  assign imm_b         = imm_b_q;
  assign branch_target = target_q;
  assign br_type       = br_type_q;
  assign is_branch     = is_branch_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_inst_b_decoder.sv
// Scoreboard bench for inst_b_decoder: directed vectors push hand-computed results,
// a negedge monitor pops them when out_valid rises and checks held values otherwise.
module tb_inst_b_decoder;

  typedef struct packed {
    logic [6:0]  imm_msb;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  imm_lsb;
    logic [31:0] imm_b;
    logic [31:0] tgt;
    logic [5:0]  br_type;
    logic        is_branch;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction_word;
  logic [31:0] pc;
  logic        out_valid;
  logic [6:0]  imm_MSB;
  logic [4:0]  rs2, rs1, imm_LSB;
  logic [2:0]  funct3;
  logic [31:0] imm_b, branch_target;
  logic [5:0]  br_type;
  logic        is_branch, illegal;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb_q[$];
  bit   mon_en  = 1'b0;

  inst_b_decoder #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .instruction_word(instruction_word), .pc(pc),
    .out_valid(out_valid), .imm_MSB(imm_MSB), .rs2(rs2), .rs1(rs1),
    .funct3(funct3), .imm_LSB(imm_LSB), .imm_b(imm_b),
    .branch_target(branch_target), .br_type(br_type),
    .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic r, input logic [31:0] iw,
                       input logic [31:0] p, input exp_t e);
    @(posedge clk);
    #1;
    in_valid = v;
    rst_n = r;
    instruction_word = iw;
    pc = p;
    if (v && r) sb_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] junk);
    drive(1'b0, 1'b1, junk, ~junk, '0);
  endtask

  // Monitor: expected out_valid follows the beat accepted one negedge earlier.
  initial begin
    exp_t hold_exp;
    bit   rst_seen;
    bit   prev_v;
    hold_exp = '0;
    rst_seen = 1'b0;
    prev_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seen) hold_exp = '0;
      if (mon_en) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, prev_v});
        if (prev_v) begin
          if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else hold_exp = sb_q.pop_front();
        end
        chk("imm_MSB",       {25'b0, imm_MSB}, {25'b0, hold_exp.imm_msb});
        chk("rs2",           {27'b0, rs2},     {27'b0, hold_exp.rs2});
        chk("rs1",           {27'b0, rs1},     {27'b0, hold_exp.rs1});
        chk("funct3",        {29'b0, funct3},  {29'b0, hold_exp.funct3});
        chk("imm_LSB",       {27'b0, imm_LSB}, {27'b0, hold_exp.imm_lsb});
        chk("imm_b",         imm_b,            hold_exp.imm_b);
        chk("branch_target", branch_target,    hold_exp.tgt);
        chk("br_type",       {26'b0, br_type}, {26'b0, hold_exp.br_type});
        chk("is_branch",     {31'b0, is_branch}, {31'b0, hold_exp.is_branch});
        chk("illegal",       {31'b0, illegal}, {31'b0, hold_exp.illegal});
      end
      rst_seen = !rst_n;
      prev_v   = in_valid && rst_n;
    end
  end

  initial begin
    exp_t e1, e2, e3, e4, e5, e6, e7, e8, e9;
    logic [31:0] iw1, iw2, iw3, iw4, iw5, iw6, iw7, iw8, iw9;
    // order: imm_msb, rs2, rs1, funct3, imm_lsb, imm_b, tgt, br_type, is_branch, illegal
    iw1 = {7'b0000111, 5'b10101, 5'b01101, 3'b111, 5'b01101, 7'b1100011};
    e1  = '{7'h07, 5'd21, 5'd13, 3'd7, 5'h0D, 32'h0000_08EC, 32'h0000_18EC, 6'b100000, 1'b1, 1'b0};
    iw2 = {7'b1010101, 5'b11100, 5'b00110, 3'b100, 5'b11101, 7'b1100011};
    e2  = '{7'h55, 5'd28, 5'd6, 3'd4, 5'h1D, 32'hFFFF_FABC, 32'h0000_1ABC, 6'b000100, 1'b1, 1'b0};
    iw3 = {7'b1000100, 5'b00100, 5'b10111, 3'b000, 5'b11111, 7'b1100011};
    e3  = '{7'h44, 5'd4, 5'd23, 3'd0, 5'h1F, 32'hFFFF_F89E, 32'hFFFF_F89E, 6'b000001, 1'b1, 1'b0};
    iw4 = {7'b0000000, 5'b00011, 5'b00010, 3'b010, 5'b00100, 7'b1100011};
    e4  = '{7'h00, 5'd3, 5'd2, 3'd2, 5'h04, 32'h0000_0004, 32'h0000_0014, 6'b000000, 1'b0, 1'b1};
    iw5 = {7'b0100000, 5'b01010, 5'b01011, 3'b000, 5'b00111, 7'b0110011};
    e5  = '{7'h20, 5'd10, 5'd11, 3'd0, 5'h07, 32'h0000_0C06, 32'h0000_0D06, 6'b000000, 1'b0, 1'b0};
    iw6 = {7'b1111111, 5'b00001, 5'b00010, 3'b001, 5'b11111, 7'b1100011};
    e6  = '{7'h7F, 5'd1, 5'd2, 3'd1, 5'h1F, 32'hFFFF_FFFE, 32'h0000_003E, 6'b000010, 1'b1, 1'b0};
    iw7 = {7'b0000000, 5'b00000, 5'b00000, 3'b101, 5'b00010, 7'b1100011};
    e7  = '{7'h00, 5'd0, 5'd0, 3'd5, 5'h02, 32'h0000_0002, 32'h0000_000A, 6'b001000, 1'b1, 1'b0};
    iw8 = {7'b0000000, 5'b00000, 5'b00000, 3'b110, 5'b00000, 7'b1100011};
    e8  = '{7'h00, 5'd0, 5'd0, 3'd6, 5'h00, 32'h0000_0000, 32'hFFFF_FFFC, 6'b010000, 1'b1, 1'b0};
    iw9 = {7'b0000000, 5'b00000, 5'b00000, 3'b011, 5'b00000, 7'b1100011};
    e9  = '{7'h00, 5'd0, 5'd0, 3'd3, 5'h00, 32'h0000_0000, 32'h0000_0000, 6'b000000, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b1;
    instruction_word = iw1;
    pc = 32'h1000;
    drive(1'b1, 1'b0, iw1, 32'h1000, e1);   // reset overrides in_valid
    drive(1'b1, 1'b1, iw1, 32'h1000, e1);
    mon_en = 1'b1;
    drive(1'b1, 1'b1, iw2, 32'h2000, e2);
    drive(1'b1, 1'b1, iw3, 32'h0000, e3);
    idle(32'hFFFF_FFFF);                     // outputs must hold the iw3 decode
    idle(32'h1234_5678);
    drive(1'b1, 1'b1, iw4, 32'h0010, e4);
    idle(32'hFFFF_FFFF);
    drive(1'b1, 1'b1, iw5, 32'h0100, e5);
    drive(1'b1, 1'b1, iw6, 32'h0040, e6);
    drive(1'b1, 1'b1, iw7, 32'h0008, e7);
    drive(1'b1, 1'b1, iw8, 32'hFFFF_FFFC, e8);
    drive(1'b1, 1'b1, iw9, 32'h0000, e9);
    drive(1'b1, 1'b1, iw6, 32'h0040, e6);
    drive(1'b1, 1'b0, iw2, 32'h2000, e2);   // discarded: reset in the same cycle
    idle(32'hFFFF_FFFF);
    idle(32'h0000_0000);
    drive(1'b1, 1'b1, iw1, 32'h1000, e1);
    idle(32'hFFFF_FFFF);
    idle(32'hFFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_b_decoder.md
INST_B_DECODER -- requirements
Module: inst_b_decoder

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of pc, imm_b and branch_target.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  instruction_word/pc valid this cycle.
REQ-005 SHALL have port instruction_word  input  32  raw RV32 instruction.
REQ-006 SHALL have port pc  input  XLEN  address of instruction_word.
REQ-007 SHALL have port out_valid  output  1  decoded outputs valid.
REQ-008 SHALL have port imm_MSB  output  7  instruction_word[31:25].
REQ-009 SHALL have port rs2  output  5  instruction_word[24:20].
REQ-010 SHALL have port rs1  output  5  instruction_word[19:15].
REQ-011 SHALL have port funct3  output  3  instruction_word[14:12].
REQ-012 SHALL have port imm_LSB  output  5  instruction_word[11:7].
REQ-013 SHALL have port imm_b  output  XLEN  sign-extended B immediate.
REQ-014 SHALL have port branch_target  output  XLEN  pc + imm_b.
REQ-015 SHALL have port br_type  output  6  one-hot {bgeu,bltu,bge,blt,bne,beq}, bit0 = beq.
REQ-016 SHALL have port is_branch  output  1  legal B-type decoded.
REQ-017 SHALL have port illegal  output  1  opcode is 1100011 but funct3 is reserved.

Function
REQ-018 SHALL register all outputs; latency exactly 1 cycle from in_valid sample to out_valid.
REQ-019 out_valid SHALL equal in_valid of the previous cycle; no backpressure.
REQ-020 When in_valid=0, all field/decoded outputs SHALL hold their previous values; only out_valid deasserts.
REQ-021 Field extraction (imm_MSB, rs2, rs1, funct3, imm_LSB) SHALL be performed regardless of opcode.
REQ-022 imm_b SHALL be {imm[12]=iw[31], imm[11]=iw[7], imm[10:5]=iw[30:25], imm[4:1]=iw[11:8], imm[0]=0}, sign-extended from bit 12 to XLEN.
REQ-023 branch_target SHALL be pc + imm_b modulo 2^XLEN; wrap-around is not flagged.
REQ-024 is_branch SHALL be 1 iff iw[6:0]=1100011 and funct3 is one of 000,001,100,101,110,111.
REQ-025 br_type SHALL map funct3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; all zeros when is_branch=0.
REQ-026 illegal SHALL be 1 iff iw[6:0]=1100011 and funct3 is 010 or 011; 0 for any other opcode.
REQ-027 imm_b and branch_target SHALL be computed for any opcode; consumers qualify them with is_branch.

Reset
REQ-028 When rst_n=0 at a rising clk edge, all outputs SHALL become 0, overriding in_valid.
REQ-029 The first out_valid after reset release SHALL be one cycle after the first in_valid sampled with rst_n=1.
REQ-030 Reset asserted mid-stream SHALL discard the instruction sampled in that cycle.

Verification
REQ-031 iw=0000111_10101_01101_111_01101_1100011, pc=0x1000 -> imm_MSB=0x07, rs2=21, rs1=13, funct3=7, imm_LSB=0x0D, imm_b=0x000008EC, branch_target=0x000018EC, br_type=bgeu, is_branch=1.
REQ-032 iw=1010101_11100_00110_100_11101_1100011, pc=0x2000 -> imm_MSB=0x55, rs2=28, rs1=6, imm_LSB=0x1D, imm_b=0xFFFFFABC, branch_target=0x00001ABC, br_type=blt.
REQ-033 iw=1000100_00100_10111_000_11111_1100011, pc=0 -> rs2=4, rs1=23, imm_LSB=0x1F, imm_b=0xFFFFF89E, branch_target=0xFFFFF89E (wrap), br_type=beq.
REQ-034 Opcode 1100011 with funct3=010 -> illegal=1, is_branch=0, br_type=0; opcode 0110011 -> illegal=0, is_branch=0, fields still extracted.
REQ-035 Back-to-back in_valid for 3 cycles then in_valid=0 -> out_valid high 3 cycles one cycle late; outputs hold last decode.
REQ-036 rst_n=0 for one cycle while in_valid=1 -> next cycle all outputs 0, out_valid=0.
